// File: rtl/cam_pkg.sv
// Shared constants and controller state encoding for the CAM match array.
package cam_pkg;

    localparam int CAM_ADDR_WIDTH = 4;
    localparam int CAM_KEY_WIDTH  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } cam_state_t;

endpackage

// File: rtl/cam_entry.sv
// One CAM entry: stored key, valid bit and the equality compare against the search key.
module cam_entry
    import cam_pkg::*;
#(
    parameter int KEY_WIDTH = CAM_KEY_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_set,
    input  logic                 i_clr,
    input  logic [KEY_WIDTH-1:0] i_wr_key,
    input  logic [KEY_WIDTH-1:0] i_search_key,
    output logic                 o_valid,
    output logic                 o_match
);

    logic                 r_valid;
    logic [KEY_WIDTH-1:0] r_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
        end
    end

    // Key storage has no reset: it is never observed while the valid bit is low.
    always_ff @(posedge clk) begin
        if (i_set) begin
            r_key <= i_wr_key;
        end
    end

    assign o_valid = r_valid;
    assign o_match = r_valid && (r_key == i_search_key);

endmodule

// File: rtl/cam_match_array.sv
// Content-addressable match array: per-entry compare, registered match vector,
// valid-entry counter and a sequential one-entry-per-cycle flush controller.
module cam_match_array
    import cam_pkg::*;
#(
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
    parameter int DEPTH      = (1 << ADDR_WIDTH),
    parameter int KEY_WIDTH  = CAM_KEY_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [KEY_WIDTH-1:0]  wr_key,
    input  logic                  wr_clear,
    input  logic                  flush_req,
    output logic                  flush_busy,
    input  logic                  search_valid,
    input  logic [KEY_WIDTH-1:0]  search_key,
    output logic                  match_valid,
    output logic [DEPTH-1:0]      match_vec,
    output logic [ADDR_WIDTH:0]   entry_count,
    output cam_state_t            o_dbg_state
);

    // Write handshake: a write is taken on a rising edge where wr_valid && wr_ready.
    // wr_ready is low during a flush and in the cycle a flush is requested.

    cam_state_t            r_state;
    cam_state_t            w_next_state;
    logic [ADDR_WIDTH-1:0] r_flush_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_match_valid;
    logic [DEPTH-1:0]      r_match_vec;

    logic                  w_wr_ready;
    logic                  w_flush_busy;
    logic                  w_flush_last;
    logic                  w_in_flush;
    logic                  w_wr_fire;
    logic                  w_inc;
    logic                  w_dec;
    logic [DEPTH-1:0]      w_valid;
    logic [DEPTH-1:0]      w_match;
    logic [DEPTH-1:0]      w_set;
    logic [DEPTH-1:0]      w_clr;

    assign w_flush_last = (r_flush_ptr == ADDR_WIDTH'(DEPTH - 1));
    assign w_in_flush   = (r_state == ST_FLUSH);
    assign w_wr_fire    = wr_valid && w_wr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_wr_ready   = 1'b0;
        w_flush_busy = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_ready = !flush_req;
                if (flush_req) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                w_flush_busy = 1'b1;
                if (w_flush_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_ptr <= '0;
        end else if ((r_state == ST_IDLE) && flush_req) begin
            r_flush_ptr <= '0;
        end else if (w_in_flush) begin
            r_flush_ptr <= r_flush_ptr + 1'b1;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);

        assign w_set[gi] = w_wr_fire && !wr_clear && (wr_addr == IDX);
        assign w_clr[gi] = (w_wr_fire && wr_clear && (wr_addr == IDX))
                         || (w_in_flush && (r_flush_ptr == IDX));

        cam_entry #(
            .KEY_WIDTH (KEY_WIDTH)
        ) u_entry (
            .clk          (clk),
            .rst          (rst),
            .i_set        (w_set[gi]),
            .i_clr        (w_clr[gi]),
            .i_wr_key     (wr_key),
            .i_search_key (search_key),
            .o_valid      (w_valid[gi]),
            .o_match      (w_match[gi])
        );
    end

    // Writes and flush invalidations never coincide, so at most one of these fires.
    assign w_inc = w_wr_fire && !wr_clear && !w_valid[wr_addr];
    assign w_dec = (w_wr_fire && wr_clear && w_valid[wr_addr])
                 || (w_in_flush && w_valid[r_flush_ptr]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_inc) begin
            r_count <= r_count + 1'b1;
        end else if (w_dec) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Compare uses the pre-edge contents, so a same-edge write is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_valid <= 1'b0;
            r_match_vec   <= '0;
        end else if (search_valid) begin
            r_match_valid <= 1'b1;
            r_match_vec   <= w_match;
        end else begin
            r_match_valid <= 1'b0;
            r_match_vec   <= '0;
        end
    end

    assign wr_ready    = w_wr_ready;
    assign flush_busy  = w_flush_busy;
    assign match_valid = r_match_valid;
    assign match_vec   = r_match_vec;
    assign entry_count = r_count;
    assign o_dbg_state = r_state;

endmodule
